// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 subset datapath.
// Control outputs are decoded from the registered state and the live IR opcode.
module control_unit #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    output logic             sub,
    output logic             WE_RF,
    output logic             WE_MEM,
    output logic [1:0]       RF_din_sel,
    output logic             ULA_din2_sel,
    output logic             load_pc,
    output logic             reset_pc,
    output logic             pc_next_sel,
    output logic             pc_adder_sel,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_dbg
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             is_r, is_i, is_ld, is_sd, is_br, is_jal, is_jalr, legal;

    assign is_r    = opcode == OP_R;
    assign is_i    = opcode == OP_I;
    assign is_ld   = opcode == OP_LD;
    assign is_sd   = opcode == OP_SD;
    assign is_br   = opcode == OP_BR;
    assign is_jal  = opcode == OP_JAL;
    assign is_jalr = opcode == OP_JALR;
    assign legal   = is_r | is_i | is_ld | is_sd | is_br | is_jal | is_jalr;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        illegal_d    = illegal_q;
        sub          = 1'b0;
        WE_RF        = 1'b0;
        WE_MEM       = 1'b0;
        RF_din_sel   = 2'b00;
        ULA_din2_sel = 1'b0;
        load_pc      = 1'b0;
        reset_pc     = 1'b0;
        pc_next_sel  = 1'b0;
        pc_adder_sel = 1'b0;
        case (state_q)
            IDLE: begin
                reset_pc = 1'b1;
                state_d  = run ? FETCH : IDLE;
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                state_d   = legal ? EXEC : HALT;
                illegal_d = illegal_q | (!legal && opcode != OP_SYS);
            end
            EXEC: begin
                sub          = (is_r && funct3 == 3'b000 && funct7_5) || is_br;
                WE_RF        = is_r | is_i;
                RF_din_sel   = (is_r | is_i) ? 2'b01 : 2'b00;
                ULA_din2_sel = is_i | is_ld | is_sd | is_jalr;
                pc_next_sel  = is_jalr;
                pc_adder_sel = is_br | is_jal;
                load_pc      = is_r | is_i | is_br | is_jal | is_jalr;
                wait_d       = 4'(MEM_WAIT);
                state_d      = (is_ld | is_sd) ? MEM : (is_jal | is_jalr) ? WB : FETCH;
            end
            MEM: begin
                ULA_din2_sel = 1'b1;
                load_pc      = wait_q == 4'd0 && is_sd;
                WE_MEM       = wait_q == 4'd0 && is_sd;
                wait_d       = wait_q == 4'd0 ? wait_q : wait_q - 4'd1;
                state_d      = wait_q != 4'd0 ? MEM : is_sd ? FETCH : WB;
            end
            WB: begin
                // jal/jalr already moved the PC in EXEC; only a load moves it here
                WE_RF        = 1'b1;
                RF_din_sel   = is_ld ? 2'b00 : 2'b10;
                ULA_din2_sel = is_ld;
                load_pc      = is_ld;
                state_d      = FETCH;
            end
            default: state_d = HALT;
        endcase
        retired_d = retired_q + CNT_W'(state_d == FETCH && (state_q inside {EXEC, MEM, WB}));
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= IDLE;
            wait_q    <= 4'd0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign halted    = state_q == HALT;
    assign illegal   = illegal_q;
    assign retired   = retired_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven and randomized checks of control_unit against a per-instruction
// cycle-timeline model built from the instruction class, CPI and MEM_WAIT.
module tb_control_unit;
    localparam int MW = 2;
    localparam int CW = 4;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [11:0] RPC    = 12'h010;

    logic          CLK = 1'b0, RST_n = 1'b0, run = 1'b0, funct7_5 = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic [2:0]    funct3 = 3'd0;
    logic          sub, WE_RF, WE_MEM, ULA_din2_sel, load_pc, reset_pc, pc_next_sel, pc_adder_sel;
    logic          halted, illegal;
    logic [1:0]    RF_din_sel;
    logic [CW-1:0] retired;
    logic [2:0]    state_dbg;
    logic [11:0]   dut_ctl;

    int            vectors = 0, miscompares = 0;
    logic [CW-1:0] ret_m = '0;

    typedef struct packed {logic [2:0] st; logic [11:0] ctl;} cyc_t;
    typedef struct {logic [6:0] op; logic [2:0] f3; logic f75; logic [11:0] ex;} vec_t;
    cyc_t exp_q[$];
    vec_t tbl[9];
    logic [6:0] legal_ops[7];

    assign dut_ctl = {sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, reset_pc,
                      pc_next_sel, pc_adder_sel, halted, illegal};

    always #5 CLK = ~CLK;

    control_unit #(.MEM_WAIT(MW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_n(RST_n), .run(run), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .sub(sub), .WE_RF(WE_RF), .WE_MEM(WE_MEM), .RF_din_sel(RF_din_sel),
        .ULA_din2_sel(ULA_din2_sel), .load_pc(load_pc), .reset_pc(reset_pc),
        .pc_next_sel(pc_next_sel), .pc_adder_sel(pc_adder_sel), .halted(halted),
        .illegal(illegal), .retired(retired), .state_dbg(state_dbg)
    );

    // control word: sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, pc_next_sel, pc_adder_sel
    function automatic logic [11:0] c(input logic sb, input logic wr, input logic wm,
                                      input logic [1:0] rs, input logic ul, input logic lp,
                                      input logic pn, input logic pa);
        return {sb, wr, wm, rs, ul, lp, 1'b0, pn, pa, 2'b00};
    endfunction

    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        exp_q.delete();
        exp_q.push_back({3'd1, 12'd0});
        exp_q.push_back({3'd2, 12'd0});
        if (op == OP_R)
            exp_q.push_back({3'd3, c(f3 == 3'd0 && f75, 1, 0, 2'b01, 0, 1, 0, 0)});
        else if (op == OP_I)
            exp_q.push_back({3'd3, c(0, 1, 0, 2'b01, 1, 1, 0, 0)});
        else if (op == OP_BR)
            exp_q.push_back({3'd3, c(1, 0, 0, 2'b00, 0, 1, 0, 1)});
        else if (op == OP_JAL || op == OP_JALR) begin
            exp_q.push_back({3'd3, op == OP_JAL ? c(0, 0, 0, 2'b00, 0, 1, 0, 1)
                                                : c(0, 0, 0, 2'b00, 1, 1, 1, 0)});
            exp_q.push_back({3'd5, c(0, 1, 0, 2'b10, 0, 0, 0, 0)});
        end else begin
            exp_q.push_back({3'd3, c(0, 0, 0, 2'b00, 1, 0, 0, 0)});
            for (int i = 0; i < MW; i++) exp_q.push_back({3'd4, c(0, 0, 0, 2'b00, 1, 0, 0, 0)});
            if (op == OP_SD)
                exp_q.push_back({3'd4, c(0, 0, 1, 2'b00, 1, 1, 0, 0)});
            else begin
                exp_q.push_back({3'd4, c(0, 0, 0, 2'b00, 1, 0, 0, 0)});
                exp_q.push_back({3'd5, c(0, 1, 0, 2'b00, 1, 1, 0, 0)});
            end
        end
    endtask

    task automatic check(input string nm, input logic [2:0] st, input logic [11:0] ctl);
        vectors++;
        if (state_dbg !== st || dut_ctl !== ctl || retired !== ret_m) begin
            miscompares++;
            $display("FAIL %s @%0t: got state=%0d ctl=%b retired=%0d, expected state=%0d ctl=%b retired=%0d",
                     nm, $time, state_dbg, dut_ctl, retired, st, ctl, ret_m);
        end
    endtask

    task automatic apply(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic f75, output logic [11:0] ex);
        build(op, f3, f75);
        ex = '0;
        foreach (exp_q[k]) begin
            @(negedge CLK);
            opcode = op; funct3 = f3; funct7_5 = f75;
            #1;
            if (state_dbg == 3'd3) ex = dut_ctl;
            check(nm, exp_q[k].st, exp_q[k].ctl);
        end
        ret_m++;
    endtask

    task automatic halt_seq(input string nm, input logic [6:0] op, input logic ill);
        @(negedge CLK); opcode = op; #1 check(nm, 3'd1, 12'd0);
        @(negedge CLK); #1 check(nm, 3'd2, 12'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            opcode = OP_R; run = 1'b1;
            #1 check(nm, 3'd6, {10'd0, 1'b1, ill});
        end
    endtask

    task automatic reset_dut();
        #2 RST_n = 1'b0;
        run = 1'b0;
        ret_m = '0;
        #1 check("reset_async", 3'd0, RPC);
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK); #1 check("idle_hold", 3'd0, RPC);
        @(negedge CLK); run = 1'b1; #1 check("idle_run", 3'd0, RPC);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [11:0] ex;
        logic [6:0]  op;
        tbl[0] = '{OP_R,    3'b000, 1'b0, c(0, 1, 0, 2'b01, 0, 1, 0, 0)};
        tbl[1] = '{OP_R,    3'b000, 1'b1, c(1, 1, 0, 2'b01, 0, 1, 0, 0)};
        tbl[2] = '{OP_I,    3'b000, 1'b1, c(0, 1, 0, 2'b01, 1, 1, 0, 0)};
        tbl[3] = '{OP_LD,   3'b011, 1'b0, c(0, 0, 0, 2'b00, 1, 0, 0, 0)};
        tbl[4] = '{OP_SD,   3'b011, 1'b0, c(0, 0, 0, 2'b00, 1, 0, 0, 0)};
        tbl[5] = '{OP_BR,   3'b000, 1'b0, c(1, 0, 0, 2'b00, 0, 1, 0, 1)};
        tbl[6] = '{OP_JAL,  3'b000, 1'b0, c(0, 0, 0, 2'b00, 0, 1, 0, 1)};
        tbl[7] = '{OP_JALR, 3'b000, 1'b0, c(0, 0, 0, 2'b00, 1, 1, 1, 0)};
        tbl[8] = '{OP_R,    3'b111, 1'b1, c(0, 1, 0, 2'b01, 0, 1, 0, 0)};
        legal_ops = '{OP_R, OP_I, OP_LD, OP_SD, OP_BR, OP_JAL, OP_JALR};

        reset_dut();
        for (int i = 0; i < 9; i++) begin
            apply($sformatf("tbl%0d", i), tbl[i].op, tbl[i].f3, tbl[i].f75, ex);
            vectors++;
            if (ex !== tbl[i].ex) begin
                miscompares++;
                $display("FAIL tbl%0d_exec: got ctl=%b expected ctl=%b", i, ex, tbl[i].ex);
            end
            @(posedge CLK); #1;
            vectors++;
            if (state_dbg !== 3'd1 || retired !== ret_m) begin
                miscompares++;
                $display("FAIL tbl%0d_next_fetch: got state=%0d retired=%0d expected state=1 retired=%0d",
                         i, state_dbg, retired, ret_m);
            end
        end

        // store aborted by reset during its commit cycle: the WE_MEM pulse must not survive
        build(OP_SD, 3'b011, 1'b0);
        foreach (exp_q[k]) begin
            @(negedge CLK);
            opcode = OP_SD; funct3 = 3'b011; funct7_5 = 1'b0;
            #1 check("sd_abort", exp_q[k].st, exp_q[k].ctl);
        end
        reset_dut();

        halt_seq("illegal_op0", 7'b0000000, 1'b1);
        reset_dut();
        halt_seq("ecall", OP_SYS, 1'b0);
        reset_dut();

        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r == 0) begin
                halt_seq("rnd_sys", OP_SYS, 1'b0);
                reset_dut();
            end else if (r == 1) begin
                do op = 7'($urandom); while (op == OP_SYS || op inside {OP_R, OP_I, OP_LD, OP_SD, OP_BR, OP_JAL, OP_JALR});
                halt_seq("rnd_illegal", op, 1'b1);
                reset_dut();
            end else begin
                apply("rnd", legal_ops[$urandom_range(0, 6)], 3'($urandom), 1'($urandom), ex);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle control FSM directly upstream of the datapath; drives every datapath control input from the instruction held in the datapath IR.
- Sequences fetch, decode, execute, memory and write-back for the RV64 subset the datapath executes: add/sub, addi, ld, sd, branches, jal, jalr.
- Halts on ecall/ebreak or an illegal opcode.
- Exposes a retired-instruction counter and a state code for debug.

Parameters:
- MEM_WAIT, 0, extra wait cycles spent in MEM before a load write-back or store commit (0..15).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_n  in  1  asynchronous active-low reset.
- run  in  1  leave IDLE and begin execution.
- opcode  in  7  IR bits [6:0].
- funct3  in  3  IR bits [14:12].
- funct7_5  in  1  IR bit 30.
- sub  out  1  ALU subtract.
- WE_RF  out  1  register-file write enable.
- WE_MEM  out  1  data-memory write enable.
- RF_din_sel  out  2  00 = DM_out, 01 = ALU result, 1x = link PC.
- ULA_din2_sel  out  1  ALU operand 2: 1 = immediate, 0 = rs2.
- load_pc  out  1  PC load enable.
- reset_pc  out  1  PC reset.
- pc_next_sel  out  1  1 = rs1+imm (jalr), 0 = PC-adder path.
- pc_adder_sel  out  1  0 = PC+4, 1 = PC+imm; PC applies the branch condition internally.
- halted  out  1  FSM is in HALT.
- illegal  out  1  sticky; halt was caused by an unsupported opcode.
- retired  out  CNT_W  count of completed instructions.
- state_dbg  out  3  current state code.

Behaviour:
- Reset (RST_n low, asynchronous):
  - state = IDLE, retired = 0, illegal = 0.
  - All outputs 0 except reset_pc = 1.
  - Reset asserted mid-instruction aborts it: no WE_RF, WE_MEM or load_pc pulse after RST_n falls.
- All control outputs are combinational decodes of the registered state plus the opcode; no output registers.
- The IR loads every cycle. PC changes only in cycles with load_pc = 1, so the IR holds the current instruction until the cycle after PC moves.
- States and codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE:
  - reset_pc = 1, all other control outputs 0.
  - run = 1 -> FETCH; otherwise stay.
- FETCH: all control outputs 0 (IR captures the instruction at PC) -> DECODE.
- DECODE: all control outputs 0.
  - opcode 1110011 -> HALT.
  - opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111} -> HALT, set illegal.
  - otherwise -> EXEC.
- EXEC, per opcode:
  - R-type 0110011: sub = funct7_5 when funct3 = 000; WE_RF = 1, RF_din_sel = 01, load_pc = 1 -> FETCH.
  - I-ALU 0010011: ULA_din2_sel = 1, WE_RF = 1, RF_din_sel = 01, load_pc = 1 -> FETCH.
  - ld 0000011 and sd 0100011: ULA_din2_sel = 1, no enables -> MEM; wait counter loaded with MEM_WAIT.
  - Branch 1100011: sub = 1, ULA_din2_sel = 0, pc_adder_sel = 1, load_pc = 1 -> FETCH.
  - jal 1101111: pc_adder_sel = 1, load_pc = 1 -> WB.
  - jalr 1100111: ULA_din2_sel = 1, pc_next_sel = 1, load_pc = 1 -> WB.
- MEM:
  - ULA_din2_sel = 1 held throughout.
  - Wait counter nonzero: decrement, stay.
  - Counter = 0, load: -> WB.
  - Counter = 0, store: WE_MEM = 1, load_pc = 1 for exactly one cycle -> FETCH.
- WB:
  - load: RF_din_sel = 00, ULA_din2_sel = 1, WE_RF = 1, load_pc = 1 -> FETCH.
  - jal/jalr: RF_din_sel = 10, WE_RF = 1, load_pc = 0 (PC already moved) -> FETCH.
- HALT: all control outputs 0, halted = 1; exit only via RST_n.
- retired increments by 1 on every transition into FETCH from EXEC, MEM or WB, and wraps modulo 2^CNT_W.
- Pulse limits: exactly one WE_RF pulse per register-writing instruction and one WE_MEM pulse per store. load_pc is never asserted twice for one instruction.
- CPI: ALU and branch 3; jal/jalr 4; sd 4+MEM_WAIT; ld 5+MEM_WAIT.

Test Plan:
1. Reset then run = 1 with the IR showing add (opcode 0110011, funct7_5 = 0): state sequence 1, 2, 3, 1. In EXEC: WE_RF = 1, RF_din_sel = 01, sub = 0, load_pc = 1. retired = 1.
2. sub (funct7_5 = 1), then addi: sub = 1 on the first EXEC; ULA_din2_sel = 1 on the second EXEC; retired = 2 after 6 cycles.
3. ld with MEM_WAIT = 2: MEM lasts 3 cycles, then a single WB cycle with RF_din_sel = 00, WE_RF = 1, load_pc = 1; total 7 cycles. sd: exactly one WE_MEM pulse, in the last MEM cycle.
4. jal: EXEC has load_pc = 1, pc_adder_sel = 1. The following WB has WE_RF = 1, RF_din_sel = 10, load_pc = 0. jalr additionally asserts pc_next_sel = 1 in EXEC.
5. Opcode 0000000 at DECODE: HALT, illegal = 1, halted = 1, all enables 0 for 10 cycles. ecall gives HALT with illegal = 0.
6. RST_n dropped asynchronously mid-MEM of a store: WE_MEM never pulses, reset_pc = 1 immediately, retired = 0.
